c5_conv_sched: RTL and testbench

C5_CONV_SCHED -- requirements
Module: c5_conv_sched

---
 rtl/c5_conv_sched_pkg.sv | 19 +
 rtl/c5_conv_sched_watchdog.sv | 27 ++
 rtl/c5_conv_sched.sv | 177 +++++++++++++++++
 tb/tb_c5_conv_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c5_conv_sched_pkg.sv
// c5_sched_pkg: shared state encoding and constants for the convolution scheduler.
package c5_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    EMIT  = 3'd4,
    FIN   = 3'd5
  } state_e;

  // Quiet NaN reported when the ConvUnit never answers.
  localparam logic [15:0] FP16_NAN = 16'h7E00;

  // RUN cycles allowed before the watchdog gives up on cu_done.
  localparam int unsigned WDOG_LIMIT = 64;

endpackage

// File: rtl/c5_conv_sched_watchdog.sv
// sched_watchdog: counts consecutive RUN cycles and flags expiry on the
// last allowed cycle. Only instantiated when C5_SCHED_WATCHDOG_EN is defined.
module sched_watchdog
  import c5_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_run,
  output logic expired
);

  logic [6:0] cnt_q, cnt_d;

  // Count while in RUN, restart from zero whenever RUN is left.
  always_comb begin
    cnt_d = in_run ? cnt_q + 7'd1 : '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = in_run && (cnt_q == 7'(WDOG_LIMIT - 1));

endmodule

// File: rtl/c5_conv_sched.sv
// c5_conv_sched: sequences NUM_FILTERS filter words through an external
// ConvUnit against one latched receptive field and streams each result out.
// Optional macro C5_SCHED_WATCHDOG_EN adds a RUN timeout and wdog_err output.
module c5_conv_sched
  import c5_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int Depth       = 1,
  parameter int Size        = 5,
  parameter int NUM_FILTERS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [Depth*Size*Size*DATA_WIDTH-1:0] image,
  output logic [7:0]                           filt_addr,
  input  logic [Depth*Size*Size*DATA_WIDTH-1:0] filt_data,
  output logic                                 cu_reset,
  output logic [Depth*Size*Size*DATA_WIDTH-1:0] cu_image,
  output logic [Depth*Size*Size*DATA_WIDTH-1:0] cu_filter,
  input  logic                                 cu_done,
  input  logic [DATA_WIDTH-1:0]                cu_result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [7:0]                           out_index,
  output logic                                 busy,
  output logic                                 run_done
`ifdef C5_SCHED_WATCHDOG_EN
  ,
  output logic                                 wdog_err
`endif
);

  localparam int unsigned VW = Depth * Size * Size * DATA_WIDTH;
  localparam logic [7:0] LAST_IDX = 8'(NUM_FILTERS - 1);

  state_e          state_q, state_d;
  logic [7:0]      index_q, index_d;
  logic [7:0]      filt_addr_q, filt_addr_d;
  logic [VW-1:0]   cu_image_q, cu_image_d;
  logic [VW-1:0]   cu_filter_q, cu_filter_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]      out_index_q, out_index_d;
  logic            cu_reset_q, cu_reset_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            run_done_q, run_done_d;

`ifdef C5_SCHED_WATCHDOG_EN
  logic wdog_expired;
  logic wdog_err_q, wdog_err_d;
  logic in_run;

  assign in_run = (state_q == RUN);

  sched_watchdog u_wdog (
    .clk     (clk),
    .reset   (reset),
    .in_run  (in_run),
    .expired (wdog_expired)
  );
`endif

  // Next-state and datapath; outputs are derived from the next state so they
  // are registered alongside it rather than decoded from state_q.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cu_image_d  = cu_image_q;
    cu_filter_d = cu_filter_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
`ifdef C5_SCHED_WATCHDOG_EN
    wdog_err_d  = wdog_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cu_image_d = image;
          index_d    = '0;
          state_d    = FETCH;
`ifdef C5_SCHED_WATCHDOG_EN
          wdog_err_d = 1'b0;
`endif
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        cu_filter_d = filt_data;
        state_d     = RUN;
      end
      RUN: begin
        if (cu_done) begin
          out_data_d  = cu_result;
          out_index_d = index_q;
          state_d     = EMIT;
        end
`ifdef C5_SCHED_WATCHDOG_EN
        else if (wdog_expired) begin
          out_data_d  = DATA_WIDTH'(FP16_NAN);
          out_index_d = index_q;
          wdog_err_d  = 1'b1;
          state_d     = EMIT;
        end
`endif
      end
      EMIT: begin
        if (out_ready) begin
          if (index_q < LAST_IDX) begin
            index_d = index_q + 8'd1;
            state_d = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    filt_addr_d = (state_d == FETCH) ? index_d : filt_addr_q;
    cu_reset_d  = (state_d == IDLE) || (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == EMIT);
    run_done_d  = (state_d == FIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      filt_addr_q <= '0;
      cu_image_q  <= '0;
      cu_filter_q <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      cu_reset_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
`ifdef C5_SCHED_WATCHDOG_EN
      wdog_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      filt_addr_q <= filt_addr_d;
      cu_image_q  <= cu_image_d;
      cu_filter_q <= cu_filter_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      cu_reset_q  <= cu_reset_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      run_done_q  <= run_done_d;
`ifdef C5_SCHED_WATCHDOG_EN
      wdog_err_q  <= wdog_err_d;
`endif
    end
  end

  assign filt_addr = filt_addr_q;
  assign cu_reset  = cu_reset_q;
  assign cu_image  = cu_image_q;
  assign cu_filter = cu_filter_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign run_done  = run_done_q;
`ifdef C5_SCHED_WATCHDOG_EN
  assign wdog_err  = wdog_err_q;
`endif

endmodule

// File: tb/tb_c5_conv_sched.sv
// tb_c5_conv_sched: scoreboard bench for c5_conv_sched (NUM_FILTERS=2) with a
// behavioural ConvUnit stub (25-cycle latency) and a one-cycle filter memory.
module tb_c5_conv_sched;

  localparam int VW = 1 * 5 * 5 * 16;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [VW-1:0] image, filt_data, cu_image, cu_filter;
  logic [7:0]    filt_addr, out_index;
  logic          cu_reset, cu_done, out_valid, busy, run_done;
  logic [15:0]   cu_result, out_data;
`ifdef C5_SCHED_WATCHDOG_EN
  logic          wdog_err;
`endif

  logic [VW-1:0] img_v, f1_v;
  logic          stub_en, glitch;
  logic [4:0]    stub_cnt;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  typedef struct { logic [7:0] idx; logic [15:0] data; } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  c5_conv_sched #(.DATA_WIDTH(16), .Depth(1), .Size(5), .NUM_FILTERS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .image     (image),
    .filt_addr (filt_addr),
    .filt_data (filt_data),
    .cu_reset  (cu_reset),
    .cu_image  (cu_image),
    .cu_filter (cu_filter),
    .cu_done   (cu_done),
    .cu_result (cu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .run_done  (run_done)
`ifdef C5_SCHED_WATCHDOG_EN
    ,
    .wdog_err  (wdog_err)
`endif
  );

  // Filter memory: word valid one cycle after the address.
  always @(posedge clk) filt_data <= (filt_addr == 8'd0) ? img_v : f1_v;

  // ConvUnit stub: done 25 cycles after cu_reset drops.
  always @(posedge clk) begin
    if (cu_reset) stub_cnt <= '0;
    else if (stub_cnt != 5'd31) stub_cnt <= stub_cnt + 5'd1;
  end
  assign cu_done   = (stub_en && !cu_reset && stub_cnt == 5'd24) || glitch;
  assign cu_result = (cu_image !== img_v)  ? 16'hBAD0 :
                     (cu_filter === img_v) ? 16'h5F00 :
                     (cu_filter === f1_v)  ? 16'h5680 : 16'hBAD1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake is popped against the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      xfers++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got idx %0h data %0h expected none", out_index, out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_index", 32'(out_index), 32'(e.idx));
        chk("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] i, input logic [15:0] d);
    exp_t e;
    e.idx = i; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks until out_valid, counting from n0; bounded.
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!out_valid && n < 300) begin tick(); n++; end
  endtask

  task automatic finish_run();
    int n;
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk("run_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, x0;
    logic [15:0] d0;
    logic [7:0]  i0;
    logic        seen;
    for (int i = 0; i < 25; i++) begin
      img_v[i*16 +: 16] = (i == 24) ? 16'h4800 : 16'h4400;
      f1_v[i*16 +: 16]  = 16'h3C00;
    end
    image = img_v; reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    stub_en = 1'b1; glitch = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_run_done", 32'(run_done), 32'd0);
    chk("rst_cu_reset", 32'(cu_reset), 32'd1);
    chk("rst_filt_addr", 32'(filt_addr), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic two-filter run.
    push(8'd0, 16'h5F00); push(8'd1, 16'h5680);
    x0 = xfers;
    pulse_start();
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_cu_reset", 32'(cu_reset), 32'd0);
    tick();
    chk("load_cu_reset", 32'(cu_reset), 32'd1);
    wait_valid(2, n);
    chk("latency_f0", 32'(n), 32'd28);
    n = 0;
    while (!(out_valid && out_index == 8'd1) && n < 300) begin tick(); n++; end
    chk("f1_valid", 32'(out_valid), 32'd1);
    tick();
    chk("run_done_pulse", 32'(run_done), 32'd1);
    tick();
    chk("run_done_clear", 32'(run_done), 32'd0);
    chk("idle_after_run", 32'(busy), 32'd0);
    chk("filt_addr_last", 32'(filt_addr), 32'd1);
    chk("xfers_basic", 32'(xfers - x0), 32'd2);

    // Backpressure: hold out_ready low for 10 cycles in EMIT.
    out_ready = 1'b0;
    push(8'd0, 16'h5F00); push(8'd1, 16'h5680);
    x0 = xfers;
    pulse_start();
    chk("fetch_addr0", 32'(filt_addr), 32'd0);
    wait_valid(1, n);
    chk("bp_valid", 32'(out_valid), 32'd1);
    d0 = out_data; i0 = out_index;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'(d0));
      chk("bp_hold_index", 32'(out_index), 32'(i0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_one_xfer", 32'(xfers - x0), 32'd1);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    finish_run();
    chk("xfers_bp", 32'(xfers - x0), 32'd2);

    // start while busy is ignored (RUN and EMIT).
    push(8'd0, 16'h5F00); push(8'd1, 16'h5680);
    x0 = xfers;
    pulse_start();
    repeat (10) tick();
    pulse_start();
    wait_valid(0, n);
    pulse_start();
    finish_run();
    repeat (5) tick();
    chk("busy_no_restart", 32'(busy), 32'd0);
    chk("xfers_busy_start", 32'(xfers - x0), 32'd2);

    // cu_done glitch in FETCH must not end RUN early.
    push(8'd0, 16'h5F00); push(8'd1, 16'h5680);
    pulse_start();
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    wait_valid(2, n);
    chk("latency_glitch", 32'(n), 32'd28);
    finish_run();

    // Reset mid-RUN aborts without output.
    pulse_start();
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_busy", 32'(busy), 32'd0);
    chk("midrun_cu_reset", 32'(cu_reset), 32'd1);
    chk("midrun_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    chk("midrun_no_valid", 32'(seen), 32'd0);

    // Reset in EMIT with out_valid high.
    out_ready = 1'b0;
    pulse_start();
    wait_valid(1, n);
    chk("emit_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("emit_rst_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid || busy) seen = 1'b1; end
    chk("emit_rst_quiet", 32'(seen), 32'd0);

`ifdef C5_SCHED_WATCHDOG_EN
    // Watchdog: cu_done tied low yields NaN after 64 RUN cycles.
    stub_en = 1'b0;
    push(8'd0, 16'h7E00); push(8'd1, 16'h7E00);
    pulse_start();
    wait_valid(1, n);
    chk("wdog_latency", 32'(n), 32'd67);
    chk("wdog_err_set", 32'(wdog_err), 32'd1);
    finish_run();
    chk("wdog_err_sticky", 32'(wdog_err), 32'd1);
    stub_en = 1'b1;
    push(8'd0, 16'h5F00); push(8'd1, 16'h5680);
    pulse_start();
    chk("wdog_err_clear", 32'(wdog_err), 32'd0);
    finish_run();
    chk("wdog_err_stays_clear", 32'(wdog_err), 32'd0);
`else
    // Without the watchdog, RUN waits indefinitely for cu_done.
    stub_en = 1'b0;
    pulse_start();
    seen = 1'b0;
    repeat (150) begin tick(); if (out_valid) seen = 1'b1; end
    chk("nowdog_no_valid", 32'(seen), 32'd0);
    chk("nowdog_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stub_en = 1'b1;
    chk("nowdog_rst_busy", 32'(busy), 32'd0);
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
